// File: rtl/rgb565_pkg.sv
// rgb565_pkg
// Shared definitions for the RGB565 video path (pixel streamer and
// edge-detect filter): colour-field widths, the packed pixel type, the
// streamer FSM state encoding and a word-to-pixel conversion helper.
package rgb565_pkg;

    localparam int R_W   = 5;
    localparam int G_W   = 6;
    localparam int B_W   = 5;
    localparam int PIX_W = R_W + G_W + B_W;

    typedef struct packed {
        logic [R_W-1:0] r;
        logic [G_W-1:0] g;
        logic [B_W-1:0] b;
    } rgb565_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } streamer_state_e;

    // Reinterpret a raw 16-bit memory word as a pixel; no colour arithmetic.
    function automatic rgb565_t to_rgb565(input logic [PIX_W-1:0] word);
        return rgb565_t'(word);
    endfunction

endpackage

// File: rtl/rgb565_pixel_streamer_if.sv
// rgb565_pixel_streamer_if
// Bundles the frame-memory read port (mem_req/mem_addr/mem_ack/mem_rdata)
// and the outgoing pixel stream (pix_valid/pix_ready/pix_data/markers).
//   master : the streamer (drives requests and pixels)
//   slave  : memory plus downstream consumer
interface rgb565_pixel_streamer_if #(
    parameter int ADDR_W = 20
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [15:0]       mem_rdata;
    logic              pix_valid;
    logic              pix_ready;
    logic [15:0]       pix_data;
    logic              pix_sof;
    logic              pix_sol;
    logic              pix_eol;

    modport master (
        output mem_req, mem_addr,
        input  mem_ack, mem_rdata,
        output pix_valid, pix_data, pix_sof, pix_sol, pix_eol,
        input  pix_ready
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_ack, mem_rdata,
        input  pix_valid, pix_data, pix_sof, pix_sol, pix_eol,
        output pix_ready
    );
endinterface

// File: rtl/rgb565_pixel_streamer_fifo.sv
// pixel_fifo
// Synchronous first-word-fall-through FIFO of 16-bit pixels.
//   clk, reset_n : clock, synchronous active-low reset (empties the FIFO)
//   push_i/wdata_i : write strobe and data
//   pop_i          : remove head entry (ignored while empty)
//   rdata_o        : head entry, valid whenever empty_o=0
//   empty_o, count_o : occupancy
module pixel_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push_i,
    input  logic [15:0]   wdata_i,
    input  logic          pop_i,
    output logic [15:0]   rdata_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);
    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_s, push_ok_s, pop_ok_s;

    assign full_s    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign push_ok_s = push_i & ~full_s;
    assign pop_ok_s  = pop_i & ~empty_o;
    assign rdata_o   = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Pointer and occupancy next state; simultaneous push/pop leaves count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because empty_o qualifies them.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    pixel_fifo_checker u_chk (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push_i),
        .full_i  (full_s)
    );
endmodule

// pixel_fifo_checker
// Simulation-only property: the fetch logic never pushes into a full FIFO.
module pixel_fifo_checker (
    input logic clk,
    input logic reset_n,
    input logic push_i,
    input logic full_i
);
    property p_no_push_when_full;
        @(posedge clk) disable iff (!reset_n) !(push_i && full_i);
    endproperty
    a_no_push_when_full: assert property (p_no_push_when_full);
endmodule

// File: rtl/rgb565_pixel_streamer.sv
// rgb565_pixel_streamer
// Fetches one frame of RGB565 pixels linearly from word-addressed memory
// and streams them out with start-of-frame/line and end-of-line markers.
//   clk, reset_n : clock, synchronous active-low reset
//   frame_start  : pulse that starts a frame (ignored while busy)
//   bus (master) : memory read port + pixel stream, see rgb565_pixel_streamer_if
//   busy         : frame in progress
//   underflow    : sticky; consumer was ready while FIFO empty mid-frame
module rgb565_pixel_streamer
    import rgb565_pkg::*;
#(
    parameter int          H_ACTIVE   = 640,
    parameter int          V_ACTIVE   = 480,
    parameter int          ADDR_W     = 20,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   frame_start,
    rgb565_pixel_streamer_if.master bus,
    output logic                   busy,
    output logic                   underflow
);
    localparam int TOTAL  = H_ACTIVE * V_ACTIVE;
    localparam int FCNT_W = $clog2(TOTAL + 1);
    localparam int COL_W  = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int ROW_W  = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int FAW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW     = FAW + 1;

    streamer_state_e   state_q, state_d;
    logic              req_q, req_d;           // also the "request pending" flag
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              busy_q, busy_d;
    logic              unf_q, unf_d;
    logic              seen_q, seen_d;         // a pixel has transferred this frame

    logic              push_s, xfer_s, pix_valid_s;
    logic              col_last_s, row_last_s, fifo_empty_s;
    logic [15:0]       fifo_rdata_s;
    logic [CW-1:0]     fifo_cnt_s;
    rgb565_t           head_s;

    // A word is written only when it completes our own request, so stray
    // acks (no request outstanding, or left over from before a reset) drop.
    assign push_s      = req_q & bus.mem_ack;
    assign pix_valid_s = ~fifo_empty_s;
    assign xfer_s      = pix_valid_s & bus.pix_ready;
    assign col_last_s  = (col_q == COL_W'(H_ACTIVE - 1));
    assign row_last_s  = (row_q == ROW_W'(V_ACTIVE - 1));
    assign head_s      = to_rgb565(fifo_rdata_s);

    pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push_s),
        .wdata_i (bus.mem_rdata),
        .pop_i   (xfer_s),
        .rdata_o (fifo_rdata_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_cnt_s)
    );

    assign bus.mem_req   = req_q;
    assign bus.mem_addr  = addr_q;
    assign bus.pix_valid = pix_valid_s;
    assign bus.pix_data  = pix_valid_s ? head_s : 16'h0000;
    assign bus.pix_sof   = pix_valid_s & (col_q == '0) & (row_q == '0);
    assign bus.pix_sol   = pix_valid_s & (col_q == '0);
    assign bus.pix_eol   = pix_valid_s & col_last_s;
    assign busy          = busy_q;
    assign underflow     = unf_q;

    // Next-state logic: output counters and underflow first, then the FSM.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        fcnt_d  = fcnt_q;
        col_d   = col_q;
        row_d   = row_q;
        busy_d  = busy_q;
        unf_d   = unf_q;
        seen_d  = seen_q;

        if (xfer_s) begin
            seen_d = 1'b1;
            if (col_last_s) begin
                col_d = '0;
                row_d = row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end else begin
            seen_d = seen_q;
        end

        if (busy_q && bus.pix_ready && !pix_valid_s && seen_q) begin
            unf_d = 1'b1;
        end else begin
            unf_d = unf_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d = ST_FETCH;
                    busy_d  = 1'b1;
                    unf_d   = 1'b0;
                    seen_d  = 1'b0;
                    addr_d  = ADDR_W'(BASE_ADDR);
                    fcnt_d  = '0;
                    col_d   = '0;
                    row_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (req_q) begin
                    if (bus.mem_ack) begin
                        req_d  = 1'b0;
                        addr_d = addr_q + ADDR_W'(1);
                        fcnt_d = fcnt_q + FCNT_W'(1);
                        if (fcnt_q == FCNT_W'(TOTAL - 1)) begin
                            state_d = ST_DRAIN;
                        end else begin
                            state_d = ST_FETCH;
                        end
                    end else begin
                        req_d = 1'b1;
                    end
                end else if (fifo_cnt_s < CW'(FIFO_DEPTH)) begin
                    // Nothing pending here, so FIFO count alone bounds the room left.
                    req_d = 1'b1;
                end else begin
                    req_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (xfer_s && col_last_s && row_last_s) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            fcnt_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            busy_q  <= 1'b0;
            unf_q   <= 1'b0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            fcnt_q  <= fcnt_d;
            col_q   <= col_d;
            row_q   <= row_d;
            busy_q  <= busy_d;
            unf_q   <= unf_d;
            seen_q  <= seen_d;
        end
    end
endmodule

// File: tb/tb_rgb565_pixel_streamer.sv
// Bench for rgb565_pixel_streamer with a 4x2 frame at 0x100 and a 4-deep FIFO.
module tb_rgb565_pixel_streamer;
    localparam int H    = 4;
    localparam int V    = 2;
    localparam int BASE = 32'h100;
    localparam int NPIX = H * V;

    typedef struct {
        int ack_delay;    // cycles mem_req is seen before the ack cycle
        int ready_mode;   // 0 always ready, 1 stall then release, 2 throttled 1-in-4
        bit mid_restart;  // extra frame_start pulse mid-frame
        int exp_pixels;
        bit exp_unf;
    } vec_t;

    typedef struct packed {
        logic [15:0] data;
        logic        sof;
        logic        sol;
        logic        eol;
    } pix_t;

    logic clk = 1'b0;
    logic reset_n;
    logic frame_start;
    logic busy;
    logic underflow;

    rgb565_pixel_streamer_if #(.ADDR_W(20)) bus ();

    rgb565_pixel_streamer #(
        .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(20), .BASE_ADDR(BASE), .FIFO_DEPTH(4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .bus         (bus),
        .busy        (busy),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   idx = 0;
    int   ack_cnt = 0;
    int   xfer_cnt = 0;
    int   ack_delay = 1;
    int   wait_cnt = 0;
    bit   mem_en = 1'b1;
    bit   force_ack = 1'b0;
    pix_t sb_q[$];
    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({bus.mem_req, bus.mem_addr, bus.pix_valid, bus.pix_data,
                    bus.pix_sof, bus.pix_sol, bus.pix_eol, busy, underflow});
    endfunction

    // Memory model: acks after ack_delay cycles, data = low address bits;
    // each ack pushes the pixel the bench expects for that frame position.
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0000;
        forever begin
            pix_t e;
            @(negedge clk);
            if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
                wait_cnt    = 0;
            end else if (force_ack) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = 16'hDEAD;
                force_ack     = 1'b0;
            end else if (mem_en && bus.mem_req) begin
                if (wait_cnt == ack_delay) begin
                    check("mem_addr", 64'(bus.mem_addr), 64'(BASE + idx));
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = bus.mem_addr[15:0];
                    e.data = 16'(BASE + idx);
                    e.sof  = (idx == 0);
                    e.sol  = ((idx % H) == 0);
                    e.eol  = ((idx % H) == H - 1);
                    sb_q.push_back(e);
                    idx++;
                    ack_cnt++;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Output monitor: every accepted beat is compared with the scoreboard head.
    initial begin
        forever begin
            pix_t e;
            @(negedge clk);
            if (reset_n && bus.pix_valid && bus.pix_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pixel: got 0x%0h expected none", bus.pix_data);
                end else begin
                    e = sb_q.pop_front();
                    check("pixel", 64'({bus.pix_data, bus.pix_sof, bus.pix_sol, bus.pix_eol}), 64'(e));
                end
                xfer_cnt++;
            end
        end
    end

    task automatic start_frame();
        @(posedge clk); #1;
        frame_start = 1'b1;
        idx = 0; ack_cnt = 0; xfer_cnt = 0;
        sb_q.delete();
        @(posedge clk); #1;
        frame_start = 1'b0;
        check("busy_at_start", 64'(busy), 64'(1));
        check("underflow_cleared", 64'(underflow), 64'(0));
    endtask

    task automatic run_vec(input vec_t v);
        bit done = 1'b0;
        ack_delay = v.ack_delay;
        start_frame();
        for (int k = 0; k < 600 && !done; k++) begin
            @(posedge clk); #1;
            frame_start = (v.mid_restart && k == 6);
            case (v.ready_mode)
                1: begin
                    if (k == 40) begin
                        // FIFO full, fetch must have stopped, head held.
                        check("stall_acks", 64'(ack_cnt), 64'(4));
                        check("stall_no_req", 64'(bus.mem_req), 64'(0));
                        check("stall_head", 64'({bus.pix_valid, bus.pix_data, bus.pix_sof}),
                              64'({1'b1, 16'h0100, 1'b1}));
                    end
                    bus.pix_ready = (k >= 40);
                end
                2:       bus.pix_ready = (k >= 10) && ((k % 4) == 1);
                default: bus.pix_ready = 1'b1;
            endcase
            if (!busy) done = 1'b1;
        end
        frame_start   = 1'b0;
        bus.pix_ready = 1'b0;
        check("frame_done", 64'(done), 64'(1));
        check("pixel_count", 64'(xfer_cnt), 64'(v.exp_pixels));
        check("ack_count", 64'(ack_cnt), 64'(NPIX));
        check("underflow_end", 64'(underflow), 64'(v.exp_unf));
        check("scoreboard_empty", 64'(sb_q.size()), 64'(0));
        check("valid_after_frame", 64'(bus.pix_valid), 64'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit found = 1'b0;
        // Fetch is at most one word per two cycles, so an always-ready consumer
        // sees the FIFO empty after the first pixel: underflow is expected there.
        vecs[0] = '{ack_delay: 1, ready_mode: 0, mid_restart: 1'b0, exp_pixels: 8, exp_unf: 1'b1};
        vecs[1] = '{ack_delay: 1, ready_mode: 1, mid_restart: 1'b0, exp_pixels: 8, exp_unf: 1'b1};
        vecs[2] = '{ack_delay: 1, ready_mode: 2, mid_restart: 1'b0, exp_pixels: 8, exp_unf: 1'b0};
        vecs[3] = '{ack_delay: 5, ready_mode: 0, mid_restart: 1'b0, exp_pixels: 8, exp_unf: 1'b1};
        vecs[4] = '{ack_delay: 1, ready_mode: 2, mid_restart: 1'b1, exp_pixels: 8, exp_unf: 1'b0};
        vecs[5] = '{ack_delay: 2, ready_mode: 2, mid_restart: 1'b0, exp_pixels: 8, exp_unf: 1'b0};

        reset_n       = 1'b0;
        frame_start   = 1'b0;
        bus.pix_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_outputs", all_outputs(), 64'(0));
        end

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
        end

        // Reset mid-frame with a request outstanding.
        ack_delay = 3;
        start_frame();
        bus.pix_ready = 1'b1;
        for (int k = 0; k < 300 && !found; k++) begin
            @(posedge clk); #1;
            if (xfer_cnt >= 3 && bus.mem_req) found = 1'b1;
        end
        check("reset_setup", 64'(found), 64'(1));
        mem_en  = 1'b0;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        bus.pix_ready = 1'b0;
        sb_q.delete();
        check("reset_outputs", all_outputs(), 64'(0));
        force_ack = 1'b1;
        @(posedge clk); #1;
        check("late_ack_ignored", 64'({bus.pix_valid, bus.mem_req, busy}), 64'(0));
        @(posedge clk); #1;
        mem_en = 1'b1;
        run_vec(vecs[5]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
